apb_cfg_master: RTL and testbench

APB_CFG_MASTER -- requirements
Module: apb_cfg_master

---
 rtl/apb_cfg_pkg.sv | 24 ++
 rtl/apb_wait_timer.sv | 29 ++
 rtl/apb_cfg_master.sv | 116 +++++++++++
 tb/tb_apb_cfg_master.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/apb_cfg_pkg.sv
// apb_cfg_pkg: shared types and constants for the APB configuration master.
//   state_t          : 2-bit FSM state encoding (IDLE, SETUP, ACCESS, RESP)
//   DEFAULT_*        : default bus widths and ACCESS timeout
//   REG_*            : configuration register offsets on the APB side
package apb_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam int DEFAULT_ADDR_W  = 8;
    localparam int DEFAULT_DATA_W  = 16;
    localparam int DEFAULT_TIMEOUT = 16;

    localparam int REG_CLKDIV = 0;
    localparam int REG_HDP    = 1;
    localparam int REG_HNDP   = 2;
    localparam int REG_VDP    = 3;
    localparam int REG_VNDP   = 4;

endpackage

// File: rtl/apb_wait_timer.sv
// apb_wait_timer: 8-bit wait-state counter for the APB ACCESS phase.
//   PCLK, PRESETn : clock, asynchronous active-low reset
//   clr           : synchronous clear (wins over en)
//   en            : count one wait cycle
//   expired       : count has reached LIMIT-1
module apb_wait_timer #(
    parameter int LIMIT = 16
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [7:0] cnt;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)
            cnt <= 8'd0;
        else if (clr)
            cnt <= 8'd0;
        else if (en)
            cnt <= cnt + 8'd1;
    end

    assign expired = (cnt == 8'(LIMIT - 1));

endmodule

// File: rtl/apb_cfg_master.sv
// apb_cfg_master: command/response front end driving a single APB3 master port.
//   PCLK, PRESETn                         : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready, cmd_write,
//   cmd_addr, cmd_wdata                   : command handshake and payload
//   rsp_valid/rsp_ready, rsp_rdata,
//   rsp_err, rsp_timeout                  : response handshake and payload
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA,
//   PRDATA, PREADY, PSLVERR               : APB master interface
module apb_cfg_master
    import apb_cfg_pkg::*;
#(
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    state_t state, state_nxt;
    logic   accept, done, tmo, expired;

    // Completion has priority over timeout on the final ACCESS cycle.
    assign accept = cmd_valid && (state == ST_IDLE);
    assign done   = (state == ST_ACCESS) && PREADY;
    assign tmo    = (state == ST_ACCESS) && !PREADY && expired;

    apb_wait_timer #(.LIMIT(TIMEOUT)) u_timer (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .clr     (accept),
        .en      ((state == ST_ACCESS) && !PREADY),
        .expired (expired)
    );

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Bus strobes and handshakes decode only the state register, so no
    // combinational path exists from the APB slave inputs to any output.
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        PSEL      = 1'b0;
        PENABLE   = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                state_nxt = cmd_valid ? ST_SETUP : ST_IDLE;
            end
            ST_SETUP: begin
                PSEL      = 1'b1;
                state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                PSEL      = 1'b1;
                PENABLE   = 1'b1;
                state_nxt = (done || tmo) ? ST_RESP : ST_ACCESS;
            end
            default: begin
                rsp_valid = 1'b1;
                state_nxt = rsp_ready ? ST_IDLE : ST_RESP;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            if (accept) begin
                PWRITE <= cmd_write;
                PADDR  <= cmd_addr;
                PWDATA <= cmd_wdata;
            end
            if (done) begin
                rsp_rdata   <= PWRITE ? '0 : PRDATA;
                rsp_err     <= PSLVERR;
                rsp_timeout <= 1'b0;
            end else if (tmo) begin
                rsp_rdata   <= '0;
                rsp_err     <= 1'b1;
                rsp_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apb_cfg_master.sv
// tb_apb_cfg_master: directed self-checking bench for apb_cfg_master.
module tb_apb_cfg_master;
    import apb_cfg_pkg::*;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [7:0]  cmd_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [15:0] rsp_rdata;
    logic        PSEL, PENABLE, PWRITE;
    logic [7:0]  PADDR;
    logic [15:0] PWDATA, PRDATA;
    logic        PREADY, PSLVERR;

    int tests = 0;
    int fails = 0;
    int cyc;

    apb_cfg_master #(.ADDR_W(8), .DATA_W(16), .TIMEOUT(16)) dut (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present a command at a falling edge; returns at the falling edge of SETUP.
    task automatic issue(input logic w, input logic [7:0] a, input logic [15:0] d);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        @(negedge PCLK);
        cmd_valid = 1'b0;
    endtask

    // Counts falling edges until rsp_valid, bounded.
    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge PCLK);
            n++;
        end
        chk("rsp_valid_within_bound", {31'd0, rsp_valid}, 32'd1);
    endtask

    initial begin
        PRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b1; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        repeat (2) @(negedge PCLK);
        chk("rst_psel", {31'd0, PSEL}, 32'd0);
        chk("rst_penable", {31'd0, PENABLE}, 32'd0);
        chk("rst_pwrite", {31'd0, PWRITE}, 32'd0);
        chk("rst_paddr", {24'd0, PADDR}, 32'd0);
        chk("rst_pwdata", {16'd0, PWDATA}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
        chk("rst_rsp_err", {30'd0, rsp_err, rsp_timeout}, 32'd0);

        // Read 0x02, immediate PREADY; command offered right at reset release
        PRESETn = 1'b1;
        #1 chk("rel_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        issue(1'b0, 8'(REG_HNDP), 16'h0000);
        chk("rd_setup_psel_pen", {30'd0, PSEL, PENABLE}, 32'b10);
        chk("rd_setup_paddr", {24'd0, PADDR}, 32'h02);
        chk("rd_setup_pwrite", {31'd0, PWRITE}, 32'd0);
        PREADY = 1'b1; PRDATA = 16'h1234;
        @(negedge PCLK);
        chk("rd_access_psel_pen", {30'd0, PSEL, PENABLE}, 32'b11);
        @(negedge PCLK);
        PREADY = 1'b0; PRDATA = 16'hDEAD;
        chk("rd_rsp_valid_n3", {31'd0, rsp_valid}, 32'd1);
        chk("rd_rsp_rdata", {16'd0, rsp_rdata}, 32'h1234);
        chk("rd_rsp_err_tmo", {30'd0, rsp_err, rsp_timeout}, 32'd0);
        chk("rd_resp_bus_idle", {29'd0, PSEL, PENABLE, cmd_ready}, 32'd0);
        @(negedge PCLK);
        chk("rd_after_idle", {30'd0, rsp_valid, cmd_ready}, 32'b01);
        chk("rd_paddr_retained", {24'd0, PADDR}, 32'h02);

        // Write 0x04 = 0xBEEF with three wait states; slave read data must be ignored
        issue(1'b1, 8'(REG_VNDP), 16'hBEEF);
        PRDATA = 16'hAAAA;
        for (int i = 0; i < 4; i++) begin
            @(negedge PCLK);
            chk("wr_access_psel_pen", {30'd0, PSEL, PENABLE}, 32'b11);
            chk("wr_access_paddr", {24'd0, PADDR}, 32'h04);
            chk("wr_access_pwdata", {16'd0, PWDATA}, 32'hBEEF);
            chk("wr_access_pwrite", {31'd0, PWRITE}, 32'd1);
            if (i == 3) PREADY = 1'b1;
        end
        @(negedge PCLK);
        PREADY = 1'b0;
        chk("wr_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("wr_rsp_rdata", {16'd0, rsp_rdata}, 32'h0000);
        chk("wr_rsp_err_tmo", {30'd0, rsp_err, rsp_timeout}, 32'd0);
        @(negedge PCLK);

        // PSLVERR during wait cycles only: no error
        issue(1'b0, 8'(REG_VDP), 16'h0);
        PSLVERR = 1'b1;
        repeat (2) @(negedge PCLK);
        PSLVERR = 1'b0; PREADY = 1'b1; PRDATA = 16'h0F0F;
        @(negedge PCLK);
        PREADY = 1'b0;
        chk("slverr_wait_rdata", {16'd0, rsp_rdata}, 32'h0F0F);
        chk("slverr_wait_err_tmo", {30'd0, rsp_err, rsp_timeout}, 32'b00);
        @(negedge PCLK);

        // PSLVERR at completion
        issue(1'b0, 8'(REG_HDP), 16'h0);
        PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 16'h7777;
        @(negedge PCLK);
        @(negedge PCLK);
        PREADY = 1'b0; PSLVERR = 1'b0;
        chk("slverr_done_valid", {31'd0, rsp_valid}, 32'd1);
        chk("slverr_done_err_tmo", {30'd0, rsp_err, rsp_timeout}, 32'b10);
        @(negedge PCLK);

        // PREADY never asserted: 16 ACCESS cycles then timeout
        issue(1'b0, 8'(REG_CLKDIV), 16'h0);
        PRDATA = 16'h5555;
        cyc = 0;
        @(negedge PCLK);
        while (PSEL && PENABLE && cyc < 40) begin
            cyc++;
            @(negedge PCLK);
        end
        chk("tmo_access_cycles", 32'(cyc), 32'd16);
        chk("tmo_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("tmo_err_tmo", {30'd0, rsp_err, rsp_timeout}, 32'b11);
        chk("tmo_rdata", {16'd0, rsp_rdata}, 32'h0000);
        @(negedge PCLK);

        // PREADY on the 16th ACCESS cycle: normal completion
        issue(1'b0, 8'(REG_HNDP), 16'h0);
        PRDATA = 16'h5A5A;
        cyc = 0;
        @(negedge PCLK);
        while (PSEL && PENABLE && cyc < 40) begin
            cyc++;
            if (cyc == 16) PREADY = 1'b1;
            @(negedge PCLK);
        end
        PREADY = 1'b0;
        chk("late_access_cycles", 32'(cyc), 32'd16);
        chk("late_err_tmo", {30'd0, rsp_err, rsp_timeout}, 32'b00);
        chk("late_rdata", {16'd0, rsp_rdata}, 32'h5A5A);
        @(negedge PCLK);

        // Response back-pressure with a pending command
        rsp_ready = 1'b0;
        issue(1'b0, 8'(REG_HDP), 16'h0);
        PREADY = 1'b1; PRDATA = 16'hC0DE;
        @(negedge PCLK);
        @(negedge PCLK);
        PREADY = 1'b0; PRDATA = 16'h0000;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'(REG_HDP); cmd_wdata = 16'h1111;
        for (int i = 0; i < 5; i++) begin
            chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_rsp_rdata", {16'd0, rsp_rdata}, 32'hC0DE);
            @(negedge PCLK);
        end
        rsp_ready = 1'b1;
        @(negedge PCLK);
        chk("bp_cmd_ready_after", {31'd0, cmd_ready}, 32'd1);
        @(negedge PCLK);
        cmd_valid = 1'b0;
        chk("bp_next_setup", {30'd0, PSEL, PENABLE}, 32'b10);
        chk("bp_next_paddr", {24'd0, PADDR}, 32'h01);
        chk("bp_next_pwrite", {31'd0, PWRITE}, 32'd1);
        PREADY = 1'b1;
        wait_rsp(cyc);
        PREADY = 1'b0;
        @(negedge PCLK);

        // Reset pulse during ACCESS
        issue(1'b0, 8'(REG_VNDP), 16'h0);
        @(negedge PCLK);
        chk("rst_mid_in_access", {30'd0, PSEL, PENABLE}, 32'b11);
        PRESETn = 1'b0;
        #1 chk("rst_mid_psel_pen", {30'd0, PSEL, PENABLE}, 32'b00);
        chk("rst_mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge PCLK);
        chk("rst_mid_paddr", {24'd0, PADDR}, 32'h00);
        PRESETn = 1'b1;
        issue(1'b0, 8'(REG_HNDP), 16'h0);
        PREADY = 1'b1; PRDATA = 16'h4321;
        wait_rsp(cyc);
        PREADY = 1'b0;
        chk("post_rst_latency", 32'(cyc), 32'd2);
        chk("post_rst_rdata", {16'd0, rsp_rdata}, 32'h4321);
        chk("post_rst_err_tmo", {30'd0, rsp_err, rsp_timeout}, 32'b00);
        @(negedge PCLK);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
